// File: rtl/mux4_scan_ctrl.sv
// Round-robin scan sequencer for a 4:1 mux: grants requesting channels in turn,
// holds each grant for DWELL cycles and flags the final cycle of every dwell.
module mux4_scan_ctrl #(
  parameter int DWELL     = 4,
  parameter int SKIP_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       enable,
  output logic       ch_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DWELL  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(DWELL - 1);

  state_t     r_state;
  logic       r_run;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;
  logic [1:0] r_sel;
  logic       r_en;
  logic       r_done;

  logic       w_run_nxt;
  logic       w_found;
  logic [1:0] w_cand;

  // Returns {found, channel}: first eligible channel scanning from p upward, mod 4.
  function automatic logic [2:0] find_cand(input logic [3:0] rq, input logic [1:0] p);
    logic       f;
    logic [1:0] c;
    logic [1:0] res;
    f   = 1'b0;
    res = p;
    for (int i = 0; i < 4; i++) begin
      c = p + 2'(i);
      if (!f && ((SKIP_IDLE == 0) || rq[c])) begin
        f   = 1'b1;
        res = c;
      end
    end
    return {f, res};
  endfunction

  assign w_run_nxt         = stop ? 1'b0 : (start ? 1'b1 : r_run);
  assign {w_found, w_cand} = find_cand(req, r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      r_sel   <= 2'd0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_run <= w_run_nxt;
      case (r_state)
        S_IDLE: begin
          r_en   <= 1'b0;
          r_done <= 1'b0;
          if (w_run_nxt) r_state <= S_SEARCH;
        end
        S_SEARCH: begin
          if (!w_run_nxt) begin
            r_state <= S_IDLE;
          end else if (w_found) begin
            r_sel   <= w_cand;
            r_cnt   <= CNT_INIT;
            r_en    <= 1'b1;
            r_done  <= (CNT_INIT == 8'd0);
            r_state <= S_DWELL;
          end
        end
        S_DWELL: begin
          // Dwell always runs to completion; stop only decides where we go after it.
          if (r_cnt == 8'd0) begin
            r_ptr   <= r_sel + 2'd1;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_state <= w_run_nxt ? S_SEARCH : S_IDLE;
          end else begin
            r_cnt  <= r_cnt - 8'd1;
            r_done <= (r_cnt == 8'd1);
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sel     = r_sel;
  assign enable  = r_en;
  assign ch_done = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: instance A (DWELL=4, SKIP_IDLE=1) and
// instance B (DWELL=1, SKIP_IDLE=0) share clock and reset.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, stop_a = 1'b0;
  logic [3:0] req_a = 4'h0;
  logic [1:0] sel_a;
  logic       en_a, cd_a, busy_a;
  logic       start_b = 1'b0, stop_b = 1'b0;
  logic [3:0] req_b = 4'h0;
  logic [1:0] sel_b;
  logic       en_b, cd_b, busy_b;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mux4_scan_ctrl #(.DWELL(4), .SKIP_IDLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .req(req_a),
    .sel(sel_a), .enable(en_a), .ch_done(cd_a), .busy(busy_a)
  );

  mux4_scan_ctrl #(.DWELL(1), .SKIP_IDLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .req(req_b),
    .sel(sel_b), .enable(en_b), .ch_done(cd_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int s, input int e, input int d, input int b);
    chk({tag, ".sel"},     32'(sel_a),  32'(s));
    chk({tag, ".enable"},  32'(en_a),   32'(e));
    chk({tag, ".ch_done"}, 32'(cd_a),   32'(d));
    chk({tag, ".busy"},    32'(busy_a), 32'(b));
  endtask

  task automatic chk_b(input string tag, input int s, input int e, input int d, input int b);
    chk({tag, ".sel"},     32'(sel_b),  32'(s));
    chk({tag, ".enable"},  32'(en_b),   32'(e));
    chk({tag, ".ch_done"}, 32'(cd_b),   32'(d));
    chk({tag, ".busy"},    32'(busy_b), 32'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset holds everything at zero even with start and requests present
    start_a = 1'b1; req_a = 4'hF; start_b = 1'b1;
    #1;
    chk_a("t1_async", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("t1_rst_a", 0, 0, 0, 0);
      chk_b("t1_rst_b", 0, 0, 0, 0);
    end
    start_a = 1'b0; start_b = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_a("t1_post", 0, 0, 0, 0);

    // 2: full round robin, 4-cycle dwells, one gap between
    start_a = 1'b1;
    tick();
    chk_a("t2_search", 0, 0, 0, 1);
    start_a = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_a($sformatf("t2_ch%0d_c%0d", ch, c), ch, 1, (c == 3) ? 1 : 0, 1);
      end
      tick();
      chk_a($sformatf("t2_gap%0d", ch), ch, 0, 0, 1);
    end

    // 3: sparse requests, then requests drop mid-dwell
    req_a = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_a($sformatf("t3_ch1_c%0d", c), 1, 1, (c == 3) ? 1 : 0, 1);
    end
    tick();
    chk_a("t3_gap1", 1, 0, 0, 1);
    tick(); chk_a("t3_ch3_c0", 3, 1, 0, 1);
    tick(); chk_a("t3_ch3_c1", 3, 1, 0, 1);
    req_a = 4'b0000;
    tick(); chk_a("t3_ch3_c2", 3, 1, 0, 1);
    tick(); chk_a("t3_ch3_c3", 3, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("t3_search%0d", i), 3, 0, 0, 1);
    end
    req_a = 4'b0001;
    tick(); chk_a("t3_ch0_c0", 0, 1, 0, 1);

    // 4: graceful stop inside the ch2 dwell, then start+stop together
    req_a = 4'b0100;
    tick(); chk_a("t4_ch0_c1", 0, 1, 0, 1);
    tick(); chk_a("t4_ch0_c2", 0, 1, 0, 1);
    tick(); chk_a("t4_ch0_c3", 0, 1, 1, 1);
    tick(); chk_a("t4_gap", 0, 0, 0, 1);
    tick(); chk_a("t4_ch2_c0", 2, 1, 0, 1);
    tick(); chk_a("t4_ch2_c1", 2, 1, 0, 1);
    stop_a = 1'b1;
    tick(); chk_a("t4_ch2_c2", 2, 1, 0, 1);
    stop_a = 1'b0;
    tick(); chk_a("t4_ch2_c3", 2, 1, 1, 1);
    tick(); chk_a("t4_idle", 2, 0, 0, 0);
    start_a = 1'b1; stop_a = 1'b1;
    tick(); chk_a("t4_both", 2, 0, 0, 0);
    start_a = 1'b0; stop_a = 1'b0;
    tick(); chk_a("t4_idle2", 2, 0, 0, 0);

    // 6: async reset in the 3rd dwell cycle, then restart from ch0
    req_a = 4'hF;
    start_a = 1'b1;
    tick(); chk_a("t6_search", 2, 0, 0, 1);
    start_a = 1'b0;
    tick(); chk_a("t6_ch3_c0", 3, 1, 0, 1);
    tick(); chk_a("t6_ch3_c1", 3, 1, 0, 1);
    tick(); chk_a("t6_ch3_c2", 3, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_a("t6_async", 0, 0, 0, 0);
    tick(); chk_a("t6_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(); chk_a("t6_rel", 0, 0, 0, 0);
    start_a = 1'b1;
    tick(); chk_a("t6_search2", 0, 0, 0, 1);
    start_a = 1'b0;
    tick(); chk_a("t6_ch0", 0, 1, 0, 1);

    // 5: DWELL=1, fixed scan ignoring req
    start_b = 1'b1;
    tick(); chk_b("t5_search", 0, 0, 0, 1);
    start_b = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      tick(); chk_b($sformatf("t5_ch%0d", ch), ch, 1, 1, 1);
      tick(); chk_b($sformatf("t5_gap%0d", ch), ch, 0, 0, 1);
    end
    tick(); chk_b("t5_wrap", 0, 1, 1, 1);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
